// File: rtl/bcd_stopwatch_lap.sv
// bcd_stopwatch_lap: parametrised BCD stopwatch (MM..M:SS) with push-button
// edge detection, pause-and-clear, a rollover pulse and an optional lap
// register.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined   -> a lap press in RUN captures the displayed time into lap_bcd
//   undefined -> lap_bcd is tied to zero and lap presses in RUN are ignored;
//                the lap/clear button still clears the time from PAUSE
//
// time_bcd / lap_bcd layout: [3:0] seconds ones, [7:4] seconds tens (0..5),
// then one nibble per minute digit, least significant first.

module bcd_stopwatch_lap #(
    parameter int MIN_DIGITS = 2,          // BCD minute digits, 1..4
    parameter int TICK_DIV   = 100000000,  // clk cycles per count step, >= 1
    parameter int TICK_W     = 27          // prescaler width, 2^TICK_W >= TICK_DIV
) (
    input  logic                        clk,
    input  logic                        reset,    // asynchronous, active low
    input  logic                        enable,
    input  logic                        push_m,   // start/stop button level
    input  logic                        push_l,   // lap/clear button level
    output logic [4*(MIN_DIGITS+2)-1:0] time_bcd,
    output logic [4*(MIN_DIGITS+2)-1:0] lap_bcd,
    output logic                        running,
    output logic                        wrap
);

    localparam int NUM_DIGITS = MIN_DIGITS + 2;
    localparam int TIME_W     = 4 * NUM_DIGITS;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    // Largest legal value of a digit: seconds tens stops at 5, all others at 9.
    function automatic logic [3:0] digit_max(input int idx);
        return (idx == 1) ? 4'd5 : 4'd9;
    endfunction

    logic              push_m_d;
    logic              push_l_d;
    logic              m_rise;
    logic              l_rise;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [TICK_W-1:0] prescaler;
    logic [TICK_W-1:0] prescaler_next;
    logic [TIME_W-1:0] time_q;
    logic [TIME_W-1:0] time_next;
    logic [TIME_W-1:0] time_inc;
    logic              all_max;
    logic              tick;
    logic              wrap_next;

    // Rising edges of the (already debounced, synchronous) buttons.
    assign m_rise = push_m & ~push_m_d;
    assign l_rise = push_l & ~push_l_d;

    // One prescaler period has elapsed while running.
    assign tick = (state == ST_RUN) && (prescaler == TICK_LAST);

    // Button history; reset to 1 so a button held through reset is not seen as a press.
    // NOTE: every register is written with <= so all flops sample the pre-edge values together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_m_d <= 1'b1;
            push_l_d <= 1'b1;
        end else begin
            push_m_d <= push_m;
            push_l_d <= push_l;
        end
    end

    // BCD ripple increment of the displayed time; all_max ends high only when every digit rolled over.
    always_comb begin
        // NOTE: defaults on every path first, so no latch is inferred.
        time_inc = time_q;
        all_max  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (all_max) begin
                if (time_q[4*i +: 4] == digit_max(i)) begin
                    time_inc[4*i +: 4] = 4'd0;
                end else begin
                    time_inc[4*i +: 4] = time_q[4*i +: 4] + 4'd1;
                    all_max            = 1'b0;
                end
            end
        end
    end

    // Next-state, next-time and prescaler decisions; enable low overrides everything.
    always_comb begin
        state_next     = state;
        time_next      = time_q;
        prescaler_next = prescaler;
        wrap_next      = 1'b0;

        if (!enable) begin
            state_next     = ST_IDLE;
            time_next      = '0;
            prescaler_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next     = ST_READY;
                    time_next      = '0;
                    prescaler_next = '0;
                end

                ST_READY: begin
                    // Lap/clear presses have nothing to act on here.
                    if (m_rise) begin
                        state_next = ST_RUN;
                    end
                end

                ST_RUN: begin
                    // The increment due on this edge is applied even when stopping.
                    if (tick) begin
                        prescaler_next = '0;
                        time_next      = time_inc;
                        wrap_next      = all_max;
                    end else begin
                        prescaler_next = prescaler + TICK_ONE;
                    end
                    if (m_rise) begin
                        state_next = ST_PAUSE;
                    end
                end

                ST_PAUSE: begin
                    // Start/stop wins over a simultaneous clear.
                    if (m_rise) begin
                        state_next = ST_RUN;
                    end else if (l_rise) begin
                        state_next     = ST_READY;
                        time_next      = '0;
                        prescaler_next = '0;
                    end
                end

                default: begin
                    state_next     = ST_IDLE;
                    time_next      = '0;
                    prescaler_next = '0;
                end
            endcase
        end
    end

    // Main state, time, prescaler and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            time_q    <= '0;
            prescaler <= '0;
            running   <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_next;
            time_q    <= time_next;
            prescaler <= prescaler_next;
            running   <= (state_next == ST_RUN);
            wrap      <= wrap_next;
        end
    end

    assign time_bcd = time_q;

`ifdef STOPWATCH_LAP_EN
    logic [TIME_W-1:0] lap_q;

    // Lap capture of the pre-increment time in RUN; a coincident start/stop press drops it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_q <= '0;
        end else if (enable && (state == ST_RUN) && l_rise && !m_rise) begin
            lap_q <= time_q;
        end
    end

    assign lap_bcd = lap_q;
`else
    assign lap_bcd = '0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_lap.sv
// Testbench for bcd_stopwatch_lap (MIN_DIGITS=2, TICK_DIV=4).
// Expected values come from a fixed vector table, hand-written sequences and
// a reference model that keeps time as total seconds and converts to BCD
// with plain division.

module tb_bcd_stopwatch_lap;

    localparam int MD        = 2;
    localparam int TD        = 4;
    localparam int TW        = 3;
    localparam int W         = 4 * (MD + 2);
    localparam int MAX_TOTAL = 6000;   // 100 minutes of 60 seconds

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    typedef enum int {M_IDLE, M_READY, M_RUN, M_PAUSE} mstate_t;

    typedef struct {
        bit           en;
        bit           pm;
        bit           pl;
        logic [W-1:0] t;
        bit           run;
        bit           wr;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         push_m;
    logic         push_l;
    logic [W-1:0] time_bcd;
    logic [W-1:0] lap_bcd;
    logic         running;
    logic         wrap;

    int errors = 0;
    int checks = 0;

    mstate_t m_state;
    int      m_secs;
    int      m_pre;
    int      m_lap;
    bit      m_wrap;
    bit      m_pm_d;
    bit      m_pl_d;

    vec_t vecs[21];

    bcd_stopwatch_lap #(
        .MIN_DIGITS(MD),
        .TICK_DIV  (TD),
        .TICK_W    (TW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .push_m  (push_m),
        .push_l  (push_l),
        .time_bcd(time_bcd),
        .lap_bcd (lap_bcd),
        .running (running),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int secs);
        int           mins;
        int           s;
        logic [W-1:0] r;
        mins   = secs / 60;
        s      = secs % 60;
        r      = '0;
        r[3:0] = 4'(s % 10);
        r[7:4] = 4'(s / 10);
        for (int d = 0; d < MD; d++) begin
            r[8+4*d +: 4] = 4'(mins % 10);
            mins = mins / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_secs  = 0;
        m_pre   = 0;
        m_lap   = 0;
        m_wrap  = 1'b0;
        m_pm_d  = 1'b1;
        m_pl_d  = 1'b1;
    endtask

    // One clock edge of the stopwatch behaviour, in whole seconds.
    task automatic model_step(input bit en, input bit pm, input bit pl);
        bit mr;
        bit lr;
        bit tk;
        mr     = pm && !m_pm_d;
        lr     = pl && !m_pl_d;
        m_pm_d = pm;
        m_pl_d = pl;
        m_wrap = 1'b0;
        if (!en) begin
            m_state = M_IDLE;
            m_secs  = 0;
            m_pre   = 0;
        end else begin
            case (m_state)
                M_IDLE:  m_state = M_READY;
                M_READY: if (mr) m_state = M_RUN;
                M_RUN: begin
                    tk = (m_pre == TD - 1);
                    if (lr && !mr && LAP_EN) m_lap = m_secs;
                    m_pre = (m_pre + 1) % TD;
                    if (tk) begin
                        m_secs = (m_secs + 1) % MAX_TOTAL;
                        m_wrap = (m_secs == 0);
                    end
                    if (mr) m_state = M_PAUSE;
                end
                M_PAUSE: begin
                    if (mr) begin
                        m_state = M_RUN;
                    end else if (lr) begin
                        m_state = M_READY;
                        m_secs  = 0;
                        m_pre   = 0;
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".time"}, time_bcd, to_bcd(m_secs));
        check({tag, ".lap"}, lap_bcd, to_bcd(m_lap));
        check({tag, ".running"}, W'(running), W'(m_state == M_RUN));
        check({tag, ".wrap"}, W'(wrap), W'(m_wrap));
    endtask

    // Called at a falling edge: drive inputs, advance the model, wait one cycle.
    task automatic step(input bit en, input bit pm, input bit pl, input bit full);
        enable = en;
        push_m = pm;
        push_l = pl;
        model_step(en, pm, pl);
        @(negedge clk);
        if (full) compare_all("rand");
    endtask

    // Run with buttons released until the model reaches the given seconds/prescaler in RUN.
    task automatic advance(input int secs, input int pre, input int budget, input string tag);
        int n;
        n = 0;
        while (!(m_state == M_RUN && m_secs == secs && m_pre == pre) && n < budget) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s: target not reached in %0d cycles, at %0d s, need %0d s", tag, budget, m_secs, secs);
        end
    endtask

    initial begin
        // Fixed vectors from reset: inputs and the outputs expected after the edge.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

        reset  = 1'b0;
        enable = 1'b1;
        push_m = 1'b0;
        push_l = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset.time", time_bcd, '0);
        check("reset.lap", lap_bcd, '0);
        check("reset.running", W'(running), '0);
        check("reset.wrap", W'(wrap), '0);
        reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].en, vecs[i].pm, vecs[i].pl, 1'b0);
            check($sformatf("vec%0d.time", i), time_bcd, vecs[i].t);
            check($sformatf("vec%0d.running", i), W'(running), W'(vecs[i].run));
            check($sformatf("vec%0d.wrap", i), W'(wrap), W'(vecs[i].wr));
        end

        // Start and count: first step 4 cycles after entering RUN, 0x0010 after 40.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("start.running", W'(running), W'(1));
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("count.first", time_bcd, 16'h0001);
        repeat (36) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("count.ten", time_bcd, 16'h0010);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("lap.early", lap_bcd, LAP_EN ? 16'h0010 : 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-count with a start button held through it.
        advance(83, 2, 2000, "to0123");
        check("pre_reset.time", time_bcd, 16'h0123);
        push_m = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("async_reset.time", time_bcd, '0);
        check("async_reset.lap", lap_bcd, '0);
        check("async_reset.running", W'(running), '0);
        check("async_reset.wrap", W'(wrap), '0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("post_reset.time", time_bcd, '0);
        check("post_reset.running", W'(running), '0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("held_button.running", W'(running), '0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);

        // Minute carry and full rollover.
        advance(599, 3, 30000, "to0959");
        check("carry.before", time_bcd, 16'h0959);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("carry.after", time_bcd, 16'h1000);
        advance(5999, 3, 30000, "to9959");
        check("wrap.before", time_bcd, 16'h9959);
        check("wrap.before_flag", W'(wrap), '0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("wrap.time", time_bcd, 16'h0000);
        check("wrap.flag", W'(wrap), W'(1));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("wrap.flag_drop", W'(wrap), '0);

        // Pause at 0x0012 with prescaler 2, hold, resume, pause, clear.
        advance(12, 1, 2000, "to0012");
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("pause.running", W'(running), '0);
        repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("pause.hold", time_bcd, 16'h0012);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("resume.running", W'(running), W'(1));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("resume.one", time_bcd, 16'h0012);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("resume.two", time_bcd, 16'h0013);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("clear.time", time_bcd, 16'h0000);
        check("clear.running", W'(running), '0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("ready.idle_wait", W'(running), '0);
        step(1'b1, 1'b1, 1'b0, 1'b0);

        // Lap on the tick cycle captures the pre-increment value.
        advance(37, 3, 2000, "to0037");
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("lap_tick.lap", lap_bcd, LAP_EN ? 16'h0037 : 16'h0000);
        check("lap_tick.time", time_bcd, 16'h0038);

        // Simultaneous presses: start/stop wins, lap untouched.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("both.running", W'(running), '0);
        check("both.lap", lap_bcd, LAP_EN ? 16'h0037 : 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("both.resume", W'(running), W'(1));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("disable.time", time_bcd, 16'h0000);
        check("disable.running", W'(running), '0);
        check("disable.lap", lap_bcd, LAP_EN ? 16'h0037 : 16'h0000);

        // Random button and mode activity against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
